// File: rtl/mem_boot_sequencer.sv
// Boot-time owner of the byte-wide program-memory port: streams an image in, then releases the CPU.
// Optional read-back verification of every byte is enabled by defining LOAD_VERIFY_EN.
module mem_boot_sequencer #(
  parameter int unsigned MEM_SIZE     = 8192,
  parameter logic [31:0] START_ADDR   = 32'h8000_0000,
  parameter int unsigned RESET_CYCLES = 2,
  parameter int unsigned LEN_W        = $clog2(MEM_SIZE) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [LEN_W-1:0] load_len,
  input  logic             s_valid,
  input  logic [7:0]       s_data,
  output logic             s_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_we,
  output logic [1:0]       mem_write_size,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             cpu_sel,
  output logic             cpu_reset,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      err_addr
);

  localparam int unsigned BOOT_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

`ifdef LOAD_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, CHECK = 3'd2, BOOT = 3'd3, RUN = 3'd4, FAIL = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, LOAD = 3'd1, BOOT = 3'd3, RUN = 3'd4, FAIL = 3'd5
  } state_t;
`endif

  state_t             state, state_next;
  logic [LEN_W-1:0]   count, count_next;
  logic [LEN_W-1:0]   len, len_next;
  logic [LEN_W-1:0]   len_clamped;
  logic [BOOT_W-1:0]  boot_cnt, boot_next;
  logic [31:0]        err_addr_next;
  logic               unused_rd;

`ifdef LOAD_VERIFY_EN
  logic [7:0]         byte_q, byte_next;
`endif

  assign unused_rd      = ^mem_rd;
  assign mem_write_size = 2'd0;

  // Next-state, datapath updates and the combinational memory-port drive.
  always_comb begin
    state_next    = state;
    count_next    = count;
    len_next      = len;
    boot_next     = '0;
    err_addr_next = err_addr;
`ifdef LOAD_VERIFY_EN
    byte_next     = byte_q;
`endif
    s_ready       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = START_ADDR;
    mem_wd        = 32'd0;
    len_clamped   = (load_len > LEN_W'(MEM_SIZE)) ? LEN_W'(MEM_SIZE) : load_len;

    case (state)
      IDLE, RUN, FAIL: begin
        if (start) begin
          len_next   = len_clamped;
          count_next = '0;
          state_next = (len_clamped == '0) ? BOOT : LOAD;
        end
      end
      LOAD: begin
        s_ready  = 1'b1;
        mem_addr = START_ADDR + 32'(count);
        mem_we   = s_valid;
        mem_wd   = {24'd0, s_data};
        if (s_valid) begin
`ifdef LOAD_VERIFY_EN
          byte_next  = s_data;
          state_next = CHECK;
`else
          // Count saturates at the last byte so it never exceeds MEM_SIZE-1.
          if (count == len - LEN_W'(1)) begin
            state_next = BOOT;
          end else begin
            count_next = count + LEN_W'(1);
          end
`endif
        end
      end
`ifdef LOAD_VERIFY_EN
      CHECK: begin
        mem_addr = START_ADDR + 32'(count);
        if (mem_rd[7:0] == byte_q) begin
          if (count == len - LEN_W'(1)) begin
            state_next = BOOT;
          end else begin
            count_next = count + LEN_W'(1);
            state_next = LOAD;
          end
        end else begin
          err_addr_next = START_ADDR + 32'(count);
          state_next    = FAIL;
        end
      end
`endif
      BOOT: begin
        if (boot_cnt == BOOT_W'(RESET_CYCLES - 1)) begin
          state_next = RUN;
        end else begin
          boot_next = boot_cnt + BOOT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State and registered status outputs, decoded from the next state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      count     <= '0;
      len       <= '0;
      boot_cnt  <= '0;
      err_addr  <= 32'd0;
`ifdef LOAD_VERIFY_EN
      byte_q    <= 8'd0;
`endif
      cpu_sel   <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      len       <= len_next;
      boot_cnt  <= boot_next;
      err_addr  <= err_addr_next;
`ifdef LOAD_VERIFY_EN
      byte_q    <= byte_next;
`endif
      cpu_sel   <= (state_next == BOOT) || (state_next == RUN);
      cpu_reset <= (state_next != RUN);
      busy      <= (state_next == LOAD) || (state_next == BOOT)
`ifdef LOAD_VERIFY_EN
                   || (state_next == CHECK)
`endif
                   ;
      done      <= (state_next == RUN);
      error     <= (state_next == FAIL);
    end
  end

endmodule
